// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer
// Drives the select pair (sel_a, sel_b) and enable of a 2-to-4 decoder through
// slots 0..3 in a timed round-robin scan. Each slot gets DWELL_CYCLES of enable
// followed by BLANK_CYCLES with the enable low. The select only moves on the
// edge where the enable falls (break-before-make).
// Optional feature macro: SCAN_SKIP_EN adds skip_mask[3:0] to skip slots.
module decoder_scan_sequencer #(
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       hold,
`ifdef SCAN_SKIP_EN
    input  logic [3:0] skip_mask,
`endif
    output logic       sel_a,
    output logic       sel_b,
    output logic       dec_enable,
    output logic       frame_done,
    output logic       busy
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t           state;
    logic [1:0]       slot;
    logic [CNT_W-1:0] timer;

    // Slot selection for the next advance / start.
    logic [1:0] adv_slot;
    logic       adv_ok;
    logic       adv_wrap;
    logic [1:0] start_slot;
    logic       start_ok;

`ifdef SCAN_SKIP_EN
    // First unmasked slot searching from+1, from+2, from+3, from (mod 4).
    // Returns {found, index}.
    function automatic logic [2:0] next_open(input logic [1:0] from, input logic [3:0] mask);
        logic [2:0] res;
        logic [1:0] idx;
        res = '0;
        for (int unsigned k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (!mask[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Next-slot search; a wrap (next index not above current) marks the frame end.
    always_comb begin
        logic [2:0] a;
        logic [2:0] s;
        a          = next_open(slot, skip_mask);
        s          = next_open(2'd3, skip_mask);
        adv_ok     = a[2];
        adv_slot   = a[1:0];
        adv_wrap   = a[2] && (a[1:0] <= slot);
        start_ok   = s[2];
        start_slot = s[1:0];
    end
`else
    // Plain round-robin: every slot is visited, slot 3 closes the frame.
    always_comb begin
        adv_ok     = 1'b1;
        adv_slot   = slot + 2'd1;
        adv_wrap   = (slot == 2'd3);
        start_ok   = 1'b1;
        start_slot = 2'd0;
    end
`endif

    assign sel_a = slot[1];
    assign sel_b = slot[0];

    // Scan FSM: timer, slot and all outputs; hold freezes everything but frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            slot       <= '0;
            timer      <= '0;
            dec_enable <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else if (hold) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    dec_enable <= 1'b0;
                    busy       <= 1'b0;
                    if (run && start_ok) begin
                        state      <= DWELL;
                        slot       <= start_slot;
                        timer      <= DWELL_LOAD;
                        dec_enable <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                DWELL: begin
                    if (timer == '0) begin
                        dec_enable <= 1'b0;
                        frame_done <= adv_wrap;
                        if (adv_ok) begin
                            state <= BLANK;
                            slot  <= adv_slot;
                            timer <= BLANK_LOAD;
                        end else begin
                            state <= IDLE;
                            slot  <= '0;
                            timer <= '0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                BLANK: begin
                    if (timer == '0) begin
                        if (run) begin
                            state      <= DWELL;
                            timer      <= DWELL_LOAD;
                            dec_enable <= 1'b1;
                        end else begin
                            state <= IDLE;
                            slot  <= '0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    slot       <= '0;
                    timer      <= '0;
                    dec_enable <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Testbench for decoder_scan_sequencer (DWELL_CYCLES=4, BLANK_CYCLES=2).
// Cycle-by-cycle vector table plus a hand-written async-reset sequence and a
// continuous break-before-make / frame_done checker.
module tb_decoder_scan_sequencer;

    logic clk;
    logic rst_n;
    logic run;
    logic hold;
    logic sel_a;
    logic sel_b;
    logic dec_enable;
    logic frame_done;
    logic busy;

    decoder_scan_sequencer #(
        .DWELL_CYCLES(4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .hold      (hold),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .dec_enable(dec_enable),
        .frame_done(frame_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       run;
        logic       hold;
        logic [1:0] sel;
        logic       en;
        logic       fd;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    int checks      = 0;
    int errors      = 0;
    int mon_checks  = 0;
    int mon_errors  = 0;

    task automatic add(input logic r, input logic h, input int n,
                       input logic [1:0] s, input logic e, input logic f, input logic b);
        vec_t v;
        v.run = r; v.hold = h; v.sel = s; v.en = e; v.fd = f; v.busy = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Compares {sel, en, fd, busy}.
    task automatic check(input string name, input logic [4:0] exp_v);
        logic [4:0] act;
        act = {sel_a, sel_b, dec_enable, frame_done, busy};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got sel=%b en=%b fd=%b busy=%b, expected sel=%b en=%b fd=%b busy=%b",
                     name, act[4:3], act[2], act[1], act[0],
                     exp_v[4:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    // Continuous checker: select never moves while enable stays high, and
    // frame_done only right after slot 3's dwell ends.
    logic [1:0] prev_sel;
    logic       prev_en;
    initial begin
        prev_sel = 2'd0;
        prev_en  = 1'b0;
    end
    always @(negedge clk) begin
        mon_checks++;
        if (prev_en && dec_enable && ({sel_a, sel_b} != prev_sel)) begin
            mon_errors++;
            $display("FAIL bbm: sel changed %b->%b with enable high", prev_sel, {sel_a, sel_b});
        end
        if (frame_done && !(prev_en && prev_sel == 2'd3 && !dec_enable && {sel_a, sel_b} == 2'd0)) begin
            mon_errors++;
            $display("FAIL fd_place: frame_done=1 with prev_sel=%b prev_en=%b sel=%b en=%b, expected only at slot3 dwell end",
                     prev_sel, prev_en, {sel_a, sel_b}, dec_enable);
        end
        prev_sel = {sel_a, sel_b};
        prev_en  = dec_enable;
    end

    initial begin
        // Frame 1 from idle, with a hold landing on the frame_done cycle.
        add(0, 0, 1, 2'd0, 0, 0, 0);
        add(1, 0, 4, 2'd0, 1, 0, 1);
        add(1, 0, 2, 2'd1, 0, 0, 1);
        add(1, 0, 4, 2'd1, 1, 0, 1);
        add(1, 0, 2, 2'd2, 0, 0, 1);
        add(1, 0, 4, 2'd2, 1, 0, 1);
        add(1, 0, 2, 2'd3, 0, 0, 1);
        add(1, 0, 4, 2'd3, 1, 0, 1);
        add(1, 0, 1, 2'd0, 0, 1, 1);
        add(1, 1, 1, 2'd0, 0, 0, 1);
        add(1, 0, 1, 2'd0, 0, 0, 1);
        // Slot 0 again, then run drops during slot 1's dwell.
        add(1, 0, 4, 2'd0, 1, 0, 1);
        add(1, 0, 2, 2'd1, 0, 0, 1);
        add(1, 0, 1, 2'd1, 1, 0, 1);
        add(0, 0, 3, 2'd1, 1, 0, 1);
        add(0, 0, 2, 2'd2, 0, 0, 1);
        add(0, 0, 2, 2'd0, 0, 0, 0);
        // Hold for 5 clocks mid-dwell.
        add(1, 0, 2, 2'd0, 1, 0, 1);
        add(1, 1, 5, 2'd0, 1, 0, 1);
        add(1, 0, 2, 2'd0, 1, 0, 1);
        add(1, 0, 2, 2'd1, 0, 0, 1);
        add(0, 0, 1, 2'd0, 0, 0, 0);
        // Hold in IDLE blocks the start.
        add(1, 1, 3, 2'd0, 0, 0, 0);
        add(1, 0, 4, 2'd0, 1, 0, 1);
        add(0, 0, 2, 2'd1, 0, 0, 1);
        add(0, 0, 1, 2'd0, 0, 0, 0);

        rst_n = 1'b0;
        run   = 1'b0;
        hold  = 1'b0;
        #12;
        check("reset_state", 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            run  = vecs[i].run;
            hold = vecs[i].hold;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {vecs[i].sel, vecs[i].en, vecs[i].fd, vecs[i].busy});
        end

        // Asynchronous reset mid-dwell, then restart from slot 0.
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_dwell", 5'b00101);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", 5'b00000);
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 5'b00000);
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1;
        check("restart_slot0", 5'b00101);
        repeat (4) @(posedge clk);
        #1;
        check("restart_blank_slot1", 5'b01001);
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("restart_stop_idle", 5'b00000);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks + mon_checks, errors + mon_errors);
        $finish;
    end

endmodule
